// File: rtl/mem_arbiter_pkg.sv
// Shared types for the SDRAM-port arbiter: FSM state encoding and
// arbitration mode selectors.
package apogee_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner picker: lowest index in fixed mode, first eligible
// index after the pointer (wrapping) in round-robin mode.
module arb_pick #(
    parameter int NCH = 3,
    parameter int PW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] i_elig,
    input  logic [PW-1:0]  i_ptr,
    input  logic           i_mode,
    output logic [PW-1:0]  o_grant,
    output logic           o_valid
);

    logic [PW-1:0] w_cand;

    // Loops run from the least to the most preferred candidate so the last hit wins.
    always_comb begin
        o_grant = '0;
        o_valid = |i_elig;
        w_cand  = '0;
        if (i_mode == 1'b0) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                w_cand = PW'(i);
                if (i_elig[w_cand]) o_grant = w_cand;
            end
        end else begin
            for (int k = NCH; k >= 1; k--) begin
                w_cand = PW'((int'(i_ptr) + k) % NCH);
                if (i_elig[w_cand]) o_grant = w_cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Registered N-channel arbiter in front of the shared SDRAM port: one access
// at a time, fixed-priority or round-robin, channel-0 lock and a ready timeout.
module mem_arbiter
    import apogee_mem_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int AW      = 25,
    parameter int DW      = 8,
    parameter int MODE    = ARB_FIXED,
    parameter int TIMEOUT = 64
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                lock,
    input  logic [NCH-1:0]      req,
    input  logic [NCH-1:0]      we,
    input  logic [NCH*AW-1:0]   addr,
    input  logic [NCH*DW-1:0]   wdata,
    output logic [NCH-1:0]      ack,
    output logic                err,
    output logic [DW-1:0]       rdata,
    output logic                busy,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_din,
    output logic                mem_we,
    output logic                mem_rd,
    input  logic [DW-1:0]       mem_dout,
    input  logic                mem_ready,
    output arb_state_t          o_dbg_state
);

    // Handshake: a requester raises req[i] with we/addr/wdata and holds the level
    // until ack[i] pulses for one cycle; downstream, a one-cycle mem_rd/mem_we
    // strobe is answered by a one-cycle mem_ready, or abandoned after TIMEOUT cycles.

    localparam int PW = $clog2(NCH);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [PW-1:0]    r_g;
    logic             r_we;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_flag;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_din;
    logic [DW-1:0]    r_rdata;

    logic [NCH-1:0]   w_elig;
    logic [PW-1:0]    w_grant;
    logic             w_valid;
    logic             w_cnt_last;
    logic [AW-1:0]    w_addr_arr  [NCH];
    logic [DW-1:0]    w_wdata_arr [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = addr[gi*AW +: AW];
        assign w_wdata_arr[gi] = wdata[gi*DW +: DW];
    end

    assign w_elig     = lock ? (req & NCH'(1)) : req;
    assign w_cnt_last = (r_cnt >= CNT_LAST);

    arb_pick #(
        .NCH (NCH),
        .PW  (PW)
    ) u_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .i_mode  (MODE == ARB_RR),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        ack    = '0;
        err    = 1'b0;
        busy   = 1'b1;
        mem_we = 1'b0;
        mem_rd = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_valid) w_next = ISSUE;
            end
            ISSUE: begin
                mem_we = r_we;
                mem_rd = ~r_we;
                w_next = WAIT;
            end
            // A ready coinciding with the last counted cycle is still a success.
            WAIT: begin
                if (mem_ready || w_cnt_last) w_next = DONE;
            end
            DONE: begin
                ack[r_g] = 1'b1;
                err      = r_flag;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_g        <= '0;
            r_we       <= 1'b0;
            r_ptr      <= PW'(NCH - 1);
            r_cnt      <= '0;
            r_flag     <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_g        <= w_grant;
                        r_we       <= we[w_grant];
                        r_mem_addr <= w_addr_arr[w_grant];
                        r_mem_din  <= w_wdata_arr[w_grant];
                        r_ptr      <= w_grant;
                    end
                end
                ISSUE: begin
                    r_cnt  <= '0;
                    r_flag <= 1'b0;
                end
                WAIT: begin
                    if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
                    if (mem_ready) begin
                        r_rdata <= mem_dout;
                    end else if (w_cnt_last) begin
                        r_rdata <= '0;
                        r_flag  <= 1'b1;
                    end
                end
                DONE: r_flag <= 1'b0;
                default: ;
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_din     = r_mem_din;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-priority instance (u=0) and a
// round-robin instance (u=1), both with TIMEOUT=8 and NCH=3.
module tb_mem_arbiter;
    import apogee_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]  reset_v;
    logic [1:0]  lock_v;
    logic [1:0]  ready_v;
    logic [2:0]  req_v     [2];
    logic [2:0]  we_v      [2];
    logic [74:0] addr_v    [2];
    logic [23:0] wdata_v   [2];
    logic [7:0]  dout_v    [2];
    logic [2:0]  ack_v     [2];
    logic [1:0]  err_v;
    logic [1:0]  busy_v;
    logic [1:0]  mem_we_v;
    logic [1:0]  mem_rd_v;
    logic [7:0]  rdata_v   [2];
    logic [7:0]  mem_din_v [2];
    logic [24:0] mem_addr_v[2];
    arb_state_t  dbg_v     [2];

    logic [2:0]  exp_q[$];

    for (genvar u = 0; u < 2; u++) begin : g_dut
        mem_arbiter #(
            .NCH     (3),
            .AW      (25),
            .DW      (8),
            .MODE    (u),
            .TIMEOUT (8)
        ) dut (
            .clk_sys     (clk),
            .reset       (reset_v[u]),
            .lock        (lock_v[u]),
            .req         (req_v[u]),
            .we          (we_v[u]),
            .addr        (addr_v[u]),
            .wdata       (wdata_v[u]),
            .ack         (ack_v[u]),
            .err         (err_v[u]),
            .rdata       (rdata_v[u]),
            .busy        (busy_v[u]),
            .mem_addr    (mem_addr_v[u]),
            .mem_din     (mem_din_v[u]),
            .mem_we      (mem_we_v[u]),
            .mem_rd      (mem_rd_v[u]),
            .mem_dout    (dout_v[u]),
            .mem_ready   (ready_v[u]),
            .o_dbg_state (dbg_v[u])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_chk(input int u, input string tag);
        chk({tag, " ack"},   32'(ack_v[u]), 32'(0));
        chk({tag, " err"},   32'(err_v[u]), 32'(0));
        chk({tag, " rdata"}, 32'(rdata_v[u]), 32'(0));
        chk({tag, " busy"},  32'(busy_v[u]), 32'(0));
        chk({tag, " maddr"}, 32'(mem_addr_v[u]), 32'(0));
        chk({tag, " mdin"},  32'(mem_din_v[u]), 32'(0));
        chk({tag, " mwe"},   32'(mem_we_v[u]), 32'(0));
        chk({tag, " mrd"},   32'(mem_rd_v[u]), 32'(0));
        chk({tag, " state"}, 32'(dbg_v[u]), 32'(IDLE));
    endtask

    task automatic idle(input int u, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, " idle busy"}, 32'(busy_v[u]), 32'(0));
        end
    endtask

    // One downstream transaction. gap = negedges until the strobe appears,
    // d = WAIT cycle (1-based) in which ready is returned, 0 = never (timeout).
    task automatic txn(input int u, input string tag, input int gap, input int d, input int ch,
                       input logic w, input logic [24:0] a, input logic [7:0] din,
                       input logic [7:0] dout, input logic drop, input logic scramble);
        int n;
        int nwait;
        logic [2:0] exp_ack;
        n = 0;
        while (!(mem_rd_v[u] || mem_we_v[u]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " gap"},   32'(n), 32'(gap));
        chk({tag, " rd"},    32'(mem_rd_v[u]), 32'(!w));
        chk({tag, " we"},    32'(mem_we_v[u]), 32'(w));
        chk({tag, " addr"},  32'(mem_addr_v[u]), 32'(a));
        chk({tag, " busy"},  32'(busy_v[u]), 32'(1));
        if (w) chk({tag, " din"}, 32'(mem_din_v[u]), 32'(din));
        if (scramble) wdata_v[u][ch*8 +: 8] = ~din;
        nwait = (d > 0) ? d : 8;
        for (int i = 1; i <= nwait; i++) begin
            @(negedge clk);
            chk({tag, " wait strobes"}, 32'({mem_rd_v[u], mem_we_v[u]}), 32'(0));
            chk({tag, " wait ack"},     32'(ack_v[u]), 32'(0));
            if (i == d) begin
                ready_v[u] = 1'b1;
                dout_v[u]  = dout;
            end
        end
        @(negedge clk);
        ready_v[u] = 1'b0;
        exp_ack = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        chk({tag, " ack"},   32'(ack_v[u]), 32'(exp_ack));
        chk({tag, " err"},   32'(err_v[u]), 32'(d == 0));
        chk({tag, " maddr"}, 32'(mem_addr_v[u]), 32'(a));
        if (!w) chk({tag, " rdata"}, 32'(rdata_v[u]), 32'((d == 0) ? 8'h00 : dout));
        if (w)  chk({tag, " din hold"}, 32'(mem_din_v[u]), 32'(din));
        if (scramble) wdata_v[u][ch*8 +: 8] = din;
        if (drop) req_v[u][ch] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_v = 2'b11;
        lock_v  = 2'b00;
        ready_v = 2'b00;
        for (int u = 0; u < 2; u++) begin
            req_v[u]   = 3'b000;
            we_v[u]    = 3'b100;
            addr_v[u]  = {25'h01000, 25'h0EE00, 25'h00100};
            wdata_v[u] = {8'h3C, 8'h22, 8'h11};
            dout_v[u]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        reset_chk(0, "rst0");
        reset_chk(1, "rst1");
        reset_v = 2'b00;

        // Fixed priority: all three request, served 0,1,2; ch1 read, ch2 write.
        idle(0, 2, "fp");
        req_v[0] = 3'b111;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        txn(0, "fp_ch0", 1, 2, 0, 1'b0, 25'h00100, 8'h11, 8'h5E, 1'b1, 1'b0);
        txn(0, "fp_ch1", 2, 2, 1, 1'b0, 25'h0EE00, 8'h22, 8'hA5, 1'b1, 1'b0);
        txn(0, "fp_ch2", 2, 2, 2, 1'b1, 25'h01000, 8'h3C, 8'h99, 1'b1, 1'b1);
        idle(0, 3, "fp_end");

        // Lock: only ch0 may be granted.
        lock_v[0] = 1'b1;
        req_v[0]  = 3'b110;
        idle(0, 4, "lk_masked");
        chk("lk state", 32'(dbg_v[0]), 32'(IDLE));
        req_v[0] = 3'b111;
        exp_q.push_back(3'b001);
        txn(0, "lk_ch0", 1, 1, 0, 1'b0, 25'h00100, 8'h11, 8'h33, 1'b1, 1'b0);
        idle(0, 3, "lk_after");
        lock_v[0] = 1'b0;
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        txn(0, "lk_ch1", 1, 1, 1, 1'b0, 25'h0EE00, 8'h22, 8'h66, 1'b1, 1'b0);
        txn(0, "lk_ch2", 2, 1, 2, 1'b1, 25'h01000, 8'h3C, 8'h99, 1'b1, 1'b0);
        idle(0, 2, "lk_end");

        // Timeout on ch0, then ch1 served; then ready exactly on the last cycle.
        req_v[0] = 3'b011;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        txn(0, "to_ch0", 1, 0, 0, 1'b0, 25'h00100, 8'h11, 8'hDD, 1'b1, 1'b0);
        txn(0, "to_ch1", 2, 1, 1, 1'b0, 25'h0EE00, 8'h22, 8'h5A, 1'b1, 1'b0);
        idle(0, 2, "to_mid");
        req_v[0] = 3'b001;
        exp_q.push_back(3'b001);
        txn(0, "to_edge", 1, 8, 0, 1'b0, 25'h00100, 8'h11, 8'h77, 1'b1, 1'b0);
        idle(0, 2, "to_end");

        // Reset during WAIT with a late mem_ready.
        req_v[0] = 3'b001;
        @(negedge clk);
        chk("rw issue rd", 32'(mem_rd_v[0]), 32'(1));
        @(negedge clk);
        chk("rw in wait", 32'(dbg_v[0]), 32'(WAIT));
        reset_v[0] = 1'b1;
        @(negedge clk);
        reset_v[0] = 1'b0;
        ready_v[0] = 1'b1;
        dout_v[0]  = 8'hEE;
        reset_chk(0, "rw");
        @(negedge clk);
        ready_v[0] = 1'b0;
        chk("rw late ack", 32'(ack_v[0]), 32'(0));
        chk("rw late err", 32'(err_v[0]), 32'(0));
        chk("rw regrant",  32'(dbg_v[0]), 32'(ISSUE));
        exp_q.push_back(3'b001);
        txn(0, "rw_after", 0, 1, 0, 1'b0, 25'h00100, 8'h11, 8'h42, 1'b1, 1'b0);
        idle(0, 2, "rw_end");

        // Round-robin: from reset 0,1,2; then 110 held gives 1,2,1,2.
        idle(1, 1, "rr");
        req_v[1] = 3'b111;
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        txn(1, "rr_a0", 1, 1, 0, 1'b0, 25'h00100, 8'h11, 8'h10, 1'b1, 1'b0);
        txn(1, "rr_a1", 2, 1, 1, 1'b0, 25'h0EE00, 8'h22, 8'h20, 1'b1, 1'b0);
        txn(1, "rr_a2", 2, 1, 2, 1'b1, 25'h01000, 8'h3C, 8'h30, 1'b1, 1'b0);
        idle(1, 2, "rr_mid");
        req_v[1] = 3'b110;
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b100);
        txn(1, "rr_b0", 1, 1, 1, 1'b0, 25'h0EE00, 8'h22, 8'h41, 1'b0, 1'b0);
        txn(1, "rr_b1", 2, 1, 2, 1'b1, 25'h01000, 8'h3C, 8'h42, 1'b0, 1'b0);
        txn(1, "rr_b2", 2, 1, 1, 1'b0, 25'h0EE00, 8'h22, 8'h43, 1'b0, 1'b0);
        txn(1, "rr_b3", 2, 1, 2, 1'b1, 25'h01000, 8'h3C, 8'h44, 1'b0, 1'b0);
        req_v[1] = 3'b000;
        idle(1, 2, "rr_end");

        chk("scoreboard drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
